// File: rtl/rk4_run_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : rk4_run_sequencer
//  Description : Run sequencer for the RK4 iteration datapath. Turns the
//                START/RESTART buttons into a run of n_lat steps, each DEPTH
//                cycles long, and issues the mux select, final capture,
//                display load and data clear strobes.
//  Revision    : 1.0 - initial release
// ============================================================================
module rk4_run_sequencer #(
  parameter int CW    = 16,
  parameter int DEPTH = 4,
  parameter int PW    = 4
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          start_i,
  input  logic          restart_i,
  input  logic [CW-1:0] n_steps_i,
  output logic          sel_feed_o,
  output logic          capture_o,
  output logic          ld_disp_o,
  output logic          clr_data_o,
  output logic          busy_o,
  output logic          done_o,
  output logic [CW-1:0] step_idx_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_CAPT  = 3'd2,
    S_DISP  = 3'd3,
    S_HOLD  = 3'd4,
    S_CLEAR = 3'd5
  } state_t;

  localparam logic [PW-1:0] C_PHASE_LAST = PW'(DEPTH - 1);

  state_t        state_q, state_d;
  logic [PW-1:0] phase_q, phase_d;
  logic [CW-1:0] step_q,  step_d;
  logic [CW-1:0] n_lat_q, n_lat_d;
  logic          start_q, restart_q;

  logic          start_rise;
  logic          restart_rise;
  logic          last_phase;
  logic          last_step;

  // Button history resets high so a button held through reset cannot fire.
  assign start_rise   = start_i   & ~start_q;
  assign restart_rise = restart_i & ~restart_q;
  assign last_phase   = (phase_q == C_PHASE_LAST);
  assign last_step    = (step_q == (n_lat_q - 1'b1));

  // State, counters, latched step count and button history registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      phase_q   <= '0;
      step_q    <= '0;
      n_lat_q   <= '0;
      start_q   <= 1'b1;
      restart_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      step_q    <= step_d;
      n_lat_q   <= n_lat_d;
      start_q   <= start_i;
      restart_q <= restart_i;
    end
  end

  // Next-state and counter update; RESTART takes priority over START.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    step_d  = step_q;
    n_lat_d = n_lat_q;
    unique case (state_q)
      S_IDLE: begin
        if (restart_rise) begin
          state_d = S_CLEAR;
          phase_d = '0;
          step_d  = '0;
        end else if (start_rise && (n_steps_i != '0)) begin
          state_d = S_RUN;
          n_lat_d = n_steps_i;
          phase_d = '0;
          step_d  = '0;
        end
      end
      S_RUN: begin
        if (restart_rise) begin
          state_d = S_CLEAR;
          phase_d = '0;
          step_d  = '0;
        end else if (last_phase) begin
          phase_d = '0;
          if (last_step) begin
            // Index stays on the final step so it never exceeds n_lat-1.
            state_d = S_CAPT;
          end else begin
            step_d = step_q + 1'b1;
          end
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      S_CAPT: begin
        if (restart_rise) begin
          state_d = S_CLEAR;
          phase_d = '0;
          step_d  = '0;
        end else begin
          state_d = S_DISP;
        end
      end
      S_DISP: begin
        if (restart_rise) begin
          state_d = S_CLEAR;
          phase_d = '0;
          step_d  = '0;
        end else begin
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (restart_rise) begin
          state_d = S_CLEAR;
          phase_d = '0;
          step_d  = '0;
        end
      end
      S_CLEAR: begin
        state_d = S_IDLE;
        phase_d = '0;
        step_d  = '0;
      end
      default: begin
        state_d = S_IDLE;
        phase_d = '0;
        step_d  = '0;
      end
    endcase
  end

  // Outputs depend on registered state only; strobes are mutually exclusive.
  assign sel_feed_o = (state_q == S_RUN) && (step_q != '0);
  assign capture_o  = (state_q == S_CAPT);
  assign ld_disp_o  = (state_q == S_DISP);
  assign clr_data_o = (state_q == S_CLEAR);
  assign busy_o     = (state_q == S_RUN) || (state_q == S_CAPT) || (state_q == S_DISP);
  assign done_o     = (state_q == S_HOLD);
  assign step_idx_o = step_q;

endmodule
`default_nettype wire
